// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one block-wide slow-memory port between the I-cache and D-cache.
// Latches the winning command on the memory port until mem_ready, then routes the ready pulse back.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter int ARB_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_read,
  input  logic                   i_write,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [BLOCK_WIDTH-1:0] i_wdata,
  output logic [BLOCK_WIDTH-1:0] i_rdata,
  output logic                   i_ready,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [BLOCK_WIDTH-1:0] d_wdata,
  output logic [BLOCK_WIDTH-1:0] d_rdata,
  output logic                   d_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [BLOCK_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata,
  input  logic                   mem_ready,
  output logic [1:0]             grant
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_d_q, last_d_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic req_i, req_d, pick_d, win_write;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;
  // On a tie, D wins in fixed-priority mode, or in round-robin when I went last.
  assign pick_d    = req_d & (~req_i | (ARB_MODE == 1) | ~last_d_q);
  assign win_write = pick_d ? d_write : i_write;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    state_d     = state_q;
    grant_d     = grant_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i || req_d) begin
          state_d     = S_BUSY;
          grant_d     = pick_d ? 2'b10 : 2'b01;
          last_d_d    = pick_d;
          mem_write_d = win_write;
          mem_read_d  = ~win_write;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
        end
      end
      default: begin
        // mem_addr deliberately survives completion; it only changes on the next grant.
        if (mem_ready) begin
          state_d     = S_IDLE;
          grant_d     = 2'b00;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_wdata_d = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      last_d_q    <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign grant     = grant_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_ready   = (state_q == S_BUSY) & grant_q[0] & mem_ready;
  assign d_ready   = (state_q == S_BUSY) & grant_q[1] & mem_ready;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit slow-memory port between the instruction cache and the data cache.
- Each cache connects with its unmodified memory interface (read/write level, 28-bit block address, 128-bit data, ready pulse).
- Arbitrates between the two caches, latches the winning command and holds it on the memory port until mem_ready.
- Routes the response only to the granted cache.
- Sits between both cache instances and the top-level memory pins.

Parameters:
ADDR_WIDTH, 28, block address width (word address minus 2 offset bits)
BLOCK_WIDTH, 128, cache line / memory data width
ARB_MODE, 0, 0 = round-robin between caches, 1 = fixed priority with D-cache winning

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_read  input  1  I-cache block read request (level, held until i_ready)
i_write  input  1  I-cache block write request (level)
i_addr  input  ADDR_WIDTH  I-cache block address
i_wdata  input  BLOCK_WIDTH  I-cache write data
i_rdata  output  BLOCK_WIDTH  read data to I-cache
i_ready  output  1  completion pulse to I-cache
d_read  input  1  D-cache block read request
d_write  input  1  D-cache block write request (writeback)
d_addr  input  ADDR_WIDTH  D-cache block address
d_wdata  input  BLOCK_WIDTH  D-cache write data
d_rdata  output  BLOCK_WIDTH  read data to D-cache
d_ready  output  1  completion pulse to D-cache
mem_read  output  1  memory read command
mem_write  output  1  memory write command
mem_addr  output  ADDR_WIDTH  memory block address
mem_wdata  output  BLOCK_WIDTH  memory write data
mem_rdata  input  BLOCK_WIDTH  memory read data
mem_ready  input  1  memory completion, 1-cycle pulse
grant  output  2  one-hot current owner: bit0 = I, bit1 = D; 00 when idle

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - FSM state = S_IDLE.
  - grant = 00; mem_read = mem_write = 0; mem_addr = 0; mem_wdata = 0.
  - i_ready = d_ready = 0.
  - Round-robin pointer last_d = 1, so the I-cache wins the first tie.
- Asserting rst_n low mid-transaction aborts the transaction immediately (asynchronously). No ready pulse is ever issued for the aborted transaction.
- FSM states: S_IDLE, S_BUSY.
- S_IDLE:
  - req_i = i_read|i_write; req_d = d_read|d_write.
  - If neither request is set, stay in S_IDLE.
  - If exactly one is set, that cache wins.
  - If both are set and ARB_MODE=0, the winner is D when last_d=0, else I.
  - If both are set and ARB_MODE=1, D wins.
  - On a win, at the clock edge: register the winner's addr, wdata and command into the mem_* output registers, set grant, record last_d = (winner==D), go to S_BUSY.
- Command encoding:
  - A write request takes precedence when a client asserts read and write together: mem_write=1, mem_read=0.
  - Otherwise mem_read=1.
  - Exactly one of mem_read/mem_write is high in S_BUSY.
- Latency: request sampled in cycle N, memory command visible in cycle N+1.
- S_BUSY:
  - mem_* outputs are held constant regardless of client inputs; later changes from the client are ignored.
  - When mem_ready=1: the granted cache's x_ready = mem_ready in the same cycle (combinational). The other cache's ready stays 0.
  - At that edge: mem_read, mem_write, grant and mem_wdata clear to 0, and the state returns to S_IDLE.
  - mem_addr keeps its value until the next grant.
- Data return: i_rdata = d_rdata = mem_rdata (pass-through). Only the ready pulse qualifies the data.
- Turnaround: there is always at least one S_IDLE cycle between transactions. This lets a cache update its state (e.g. writeback, then fetch) before it is re-sampled.
  - A cache doing writeback then fetch re-arbitrates for the fetch. With round-robin, a pending request from the other cache may be served in between.
- mem_ready while in S_IDLE is ignored: no ready to either cache, no state change.
- Fairness: in ARB_MODE=0, with both caches requesting continuously, grants alternate I, D, I, D. In ARB_MODE=1 the I-cache can starve; this is intentional.

Test Plan:
- Reset: rst_n=0 for 3 cycles with i_read=1 -> grant=00, mem_read=0, i_ready=0. After release, mem_read=1 with mem_addr=i_addr one cycle later.
- Single read: i_read=1, i_addr=28'h0000123; memory returns 128'hA5.. after 4 cycles with mem_ready -> i_ready pulses 1 cycle, i_rdata=128'hA5.., d_ready=0, grant back to 00 next cycle.
- Writeback then fetch: d_write=1, d_addr=28'h00000AB, d_wdata=128'hDEAD.. -> mem_write=1 with that data held until ready. Then d_read with the same address -> a second transaction starts after one S_IDLE cycle.
- Round-robin: i_read and d_read held high, memory ready at 2-cycle latency -> grant sequence 01, 10, 01, 10 over 4 transactions.
- Fixed priority (ARB_MODE=1): both requesting continuously -> grant always 10 and i_ready never pulses.
- Robustness:
  - Client changes d_addr mid-S_BUSY -> mem_addr unchanged.
  - Spurious mem_ready in S_IDLE -> no ready out.
  - rst_n low mid-S_BUSY -> mem_read drops immediately (asynchronously) and no ready pulse is issued.
